// File: rtl/pkg_cpu.sv
// Shared Jolt160 CPU/memory types: access-size encoding and arbiter FSM states.
// Lane helpers keep the byte steering rules in one place.
package pkg_cpu;

  typedef enum logic {
    cpu_data_acc_sz_8  = 1'b0,
    cpu_data_acc_sz_16 = 1'b1
  } cpu_data_acc_sz_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } mem_arb_state_t;

  function automatic logic [1:0] lane_en(logic sz16, logic a0);
    if (sz16) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [15:0] rd_steer(logic sz16, logic a0,
                                           logic [15:0] d);
    if (sz16) return d;
    return {8'h00, a0 ? d[15:8] : d[7:0]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant,
// wrapping at NUM_REQ-1.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IW-1:0]      grant_idx
);

  logic [IW-1:0] c;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    c         = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (c == IW'(NUM_REQ - 1)) ? '0 : c + IW'(1);
      if (grant_oh == '0 && req[c]) begin
        grant_oh[c] = 1'b1;
        grant_idx   = c;
      end
    end
  end

endmodule

// File: rtl/jolt160_mem_arbiter.sv
// Round-robin arbiter of NUM_REQ Jolt160 requesters onto one 16-bit
// synchronous RAM port, with byte-lane steering and misalign detection.
module jolt160_mem_arbiter
  import pkg_cpu::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_rdwr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_acc_sz,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*16-1:0]         req_wdata,
  output logic [NUM_REQ*16-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]            data_ready,
  output logic [NUM_REQ-1:0]            req_err,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-2:0]         mem_addr,
  output logic [1:0]                    mem_byte_en,
  output logic [15:0]                   mem_wdata,
  input  logic [15:0]                   mem_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [2:0]    LAT      = 3'(MEM_LATENCY);

  mem_arb_state_t state;

  logic [IW-1:0] last_grant;
  logic [IW-1:0] grant;
  logic [2:0]    cnt;
  logic          sz16;
  logic          a0;
  logic          err;
  logic [15:0]   rd_q;

  logic [NUM_REQ-1:0] g_oh;
  logic [IW-1:0]      g_idx;
  logic               g_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req        (req_rdwr),
    .last_grant (last_grant),
    .grant_oh   (g_oh),
    .grant_idx  (g_idx)
  );

  logic [ADDR_WIDTH-1:0] s_addr;
  logic                  s_sz16;
  logic                  s_we;
  logic [15:0]           s_wdata;
  logic                  s_mis;

  always_comb begin
    g_any   = |g_oh;
    s_addr  = req_addr[int'(g_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    s_sz16  = (req_acc_sz[g_idx] == cpu_data_acc_sz_16);
    s_we    = req_we[g_idx];
    s_wdata = req_wdata[int'(g_idx)*16 +: 16];
    s_mis   = s_sz16 && s_addr[0];
  end

  // RAM strobes are set on grant so they are live for exactly the ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= LAST_RST;
      grant       <= '0;
      cnt         <= '0;
      sz16        <= 1'b0;
      a0          <= 1'b0;
      err         <= 1'b0;
      rd_q        <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_byte_en <= '0;
      mem_wdata   <= '0;
      data_ready  <= '0;
      req_err     <= '0;
      req_rdata   <= '0;
    end else begin
      data_ready <= '0;
      req_err    <= '0;
      req_rdata  <= '0;
      unique case (state)
        IDLE: begin
          if (g_any) begin
            grant <= g_idx;
            sz16  <= s_sz16;
            a0    <= s_addr[0];
            err   <= s_mis;
            if (!s_mis) begin
              mem_en      <= 1'b1;
              mem_we      <= s_we;
              mem_addr    <= s_addr[ADDR_WIDTH-1:1];
              mem_byte_en <= lane_en(s_sz16, s_addr[0]);
              mem_wdata   <= s_sz16 ? s_wdata : {2{s_wdata[7:0]}};
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en      <= 1'b0;
          mem_we      <= 1'b0;
          mem_addr    <= '0;
          mem_byte_en <= '0;
          mem_wdata   <= '0;
          if (err) begin
            state <= DONE;
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            rd_q  <= mem_rdata;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          data_ready[grant] <= 1'b1;
          req_err[grant]    <= err;
          req_rdata[int'(grant)*16 +: 16] <=
            err ? 16'h0 : rd_steer(sz16, a0, rd_q);
          last_grant <= grant;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jolt160_mem_arbiter.sv
// Bench for jolt160_mem_arbiter: two DUTs (latency 1 and 4) on behavioural
// RAMs, checked against a byte-level shadow memory and round-robin model.
module tb_jolt160_mem_arbiter;
  import pkg_cpu::*;

  localparam logic SZ8  = cpu_data_acc_sz_8;
  localparam logic SZ16 = cpu_data_acc_sz_16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0]  rdwr  [2];
  logic [31:0] addr_in [2];
  logic [1:0]  sz_in [2];
  logic [1:0]  we_in [2];
  logic [31:0] wd_in [2];

  logic [31:0] rd   [2];
  logic [1:0]  dr   [2];
  logic [1:0]  er   [2];
  logic        m_en [2];
  logic        m_we [2];
  logic [14:0] m_addr [2];
  logic [1:0]  m_be [2];
  logic [15:0] m_wd [2];
  logic [15:0] m_rd [2];

  int checks = 0;
  int errors = 0;

  jolt160_mem_arbiter #(
    .NUM_REQ (2), .ADDR_WIDTH (16), .MEM_LATENCY (1)
  ) u_dut1 (
    .clk (clk), .reset (rst),
    .req_rdwr (rdwr[0]), .req_addr (addr_in[0]),
    .req_acc_sz (sz_in[0]), .req_we (we_in[0]),
    .req_wdata (wd_in[0]), .req_rdata (rd[0]),
    .data_ready (dr[0]), .req_err (er[0]),
    .mem_en (m_en[0]), .mem_we (m_we[0]),
    .mem_addr (m_addr[0]), .mem_byte_en (m_be[0]),
    .mem_wdata (m_wd[0]), .mem_rdata (m_rd[0])
  );

  jolt160_mem_arbiter #(
    .NUM_REQ (2), .ADDR_WIDTH (16), .MEM_LATENCY (4)
  ) u_dut4 (
    .clk (clk), .reset (rst),
    .req_rdwr (rdwr[1]), .req_addr (addr_in[1]),
    .req_acc_sz (sz_in[1]), .req_we (we_in[1]),
    .req_wdata (wd_in[1]), .req_rdata (rd[1]),
    .data_ready (dr[1]), .req_err (er[1]),
    .mem_en (m_en[1]), .mem_we (m_we[1]),
    .mem_addr (m_addr[1]), .mem_byte_en (m_be[1]),
    .mem_wdata (m_wd[1]), .mem_rdata (m_rd[1])
  );

  // Behavioural RAMs; read data is only valid LAT edges after the strobe.
  logic [15:0] ram  [2][256] = '{default: 16'h0};
  logic [15:0] pipe [2][8];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 1; k < 8; k++) pipe[d][k] <= pipe[d][k-1];
      if (m_en[d]) begin
        pipe[d][0] <= ram[d][m_addr[d][7:0]];
        if (m_we[d] && m_be[d][0])
          ram[d][m_addr[d][7:0]][7:0] <= m_wd[d][7:0];
        if (m_we[d] && m_be[d][1])
          ram[d][m_addr[d][7:0]][15:8] <= m_wd[d][15:8];
      end else begin
        pipe[d][0] <= 16'($urandom);
      end
    end
  end

  assign m_rd[0] = pipe[0][0];
  assign m_rd[1] = pipe[1][3];

  int          en_cnt [2] = '{0, 0};
  int          viol   [2] = '{0, 0};
  logic        cap_we [2];
  logic [14:0] cap_addr [2];
  logic [1:0]  cap_be [2];
  logic [15:0] cap_wd [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_en[d]) begin
        en_cnt[d]   <= en_cnt[d] + 1;
        cap_we[d]   <= m_we[d];
        cap_addr[d] <= m_addr[d];
        cap_be[d]   <= m_be[d];
        cap_wd[d]   <= m_wd[d];
      end else if (m_we[d] || m_addr[d] != '0 ||
                   m_be[d] != '0 || m_wd[d] != '0) begin
        viol[d] <= viol[d] + 1;
      end
      if (dr[d] == 2'b11) viol[d] <= viol[d] + 1;
    end
  end

  logic [15:0] ref_mem [2][256] = '{default: 16'h0};

  function automatic logic [15:0] ref_read(int d, logic [15:0] a, logic sz);
    logic [15:0] w;
    w = ref_mem[d][a[8:1]];
    if (sz) return w;
    return a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
  endfunction

  function automatic void ref_write(int d, logic [15:0] a, logic sz,
                                    logic [15:0] wd);
    if (sz) ref_mem[d][a[8:1]] = wd;
    else if (a[0]) ref_mem[d][a[8:1]][15:8] = wd[7:0];
    else ref_mem[d][a[8:1]][7:0] = wd[7:0];
  endfunction

  task automatic txn(input int d, input int ch, input logic [15:0] a,
                     input logic sz, input logic we,
                     input logic [15:0] wd, input bit drop);
    int n, en0, lat, oc;
    logic mis;
    logic [15:0] exp_rd;
    logic [1:0] exp_be;
    lat    = (d == 0) ? 1 : 4;
    oc     = 1 - ch;
    mis    = sz && a[0];
    exp_rd = mis ? 16'h0 : ref_read(d, a, sz);
    exp_be = sz ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
    @(negedge clk);
    en0 = en_cnt[d];
    rdwr[d][ch]              = 1'b1;
    addr_in[d][ch*16 +: 16]  = a;
    sz_in[d][ch]             = sz;
    we_in[d][ch]             = we;
    wd_in[d][ch*16 +: 16]    = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop && n == 1) rdwr[d][ch] = 1'b0;
    end while (!dr[d][ch] && n < 40);
    rdwr[d][ch] = 1'b0;
    checks++;
    if (n != (mis ? 3 : lat + 3)) begin
      errors++;
      $display("FAIL latency d%0d ch%0d got %0d exp %0d",
               d, ch, n, mis ? 3 : lat + 3);
    end
    checks++;
    if (dr[d] !== 2'(1 << ch)) begin
      errors++;
      $display("FAIL ready_vec d%0d got %b exp %b", d, dr[d], 2'(1 << ch));
    end
    checks++;
    if (er[d][ch] !== mis) begin
      errors++;
      $display("FAIL req_err d%0d ch%0d got %b exp %b", d, ch, er[d][ch], mis);
    end
    if (!we || mis) begin
      checks++;
      if (rd[d][ch*16 +: 16] !== exp_rd) begin
        errors++;
        $display("FAIL rdata d%0d ch%0d a=%h got %h exp %h",
                 d, ch, a, rd[d][ch*16 +: 16], exp_rd);
      end
    end
    checks++;
    if (rd[d][oc*16 +: 16] !== 16'h0) begin
      errors++;
      $display("FAIL idle_slice d%0d got %h exp 0000", d, rd[d][oc*16 +: 16]);
    end
    checks++;
    if (en_cnt[d] - en0 != (mis ? 0 : 1)) begin
      errors++;
      $display("FAIL mem_en_count d%0d got %0d exp %0d",
               d, en_cnt[d] - en0, mis ? 0 : 1);
    end
    if (!mis) begin
      checks++;
      if ({cap_we[d], cap_addr[d], cap_be[d]} !== {we, a[15:1], exp_be}) begin
        errors++;
        $display("FAIL mem_ctrl d%0d got we%b a%h be%b exp we%b a%h be%b",
                 d, cap_we[d], cap_addr[d], cap_be[d], we, a[15:1], exp_be);
      end
      if (we) begin
        checks++;
        if (cap_wd[d] !== (sz ? wd : {2{wd[7:0]}})) begin
          errors++;
          $display("FAIL mem_wdata d%0d got %h exp %h",
                   d, cap_wd[d], sz ? wd : {2{wd[7:0]}});
        end
        ref_write(d, a, sz, wd);
      end
    end
    @(negedge clk);
    checks++;
    if (dr[d] !== 2'b00) begin
      errors++;
      $display("FAIL ready_pulse d%0d got %b exp 00", d, dr[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({dr[d], er[d], rd[d], m_en[d], m_we[d], m_addr[d],
           m_be[d], m_wd[d]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs d%0d got nonzero exp zero", d);
      end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dr[0], dr[1], m_en[0], m_en[1]} !== '0) begin
      errors++;
      $display("FAIL idle_quiet got %b%b exp 0", dr[0], dr[1]);
    end
  endtask

  task automatic test_basic16();
    txn(0, 0, 16'h0010, SZ16, 1'b1, 16'hBEEF, 1'b0);
    txn(0, 0, 16'h0010, SZ16, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_byte_write();
    txn(0, 1, 16'h0020, SZ16, 1'b1, 16'h1177, 1'b0);
    txn(0, 1, 16'h0021, SZ8,  1'b1, 16'h005A, 1'b0);
    txn(0, 1, 16'h0020, SZ16, 1'b0, 16'h0000, 1'b0);
    txn(0, 0, 16'h0020, SZ8,  1'b0, 16'h0000, 1'b1);
    txn(0, 0, 16'h0021, SZ8,  1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_misaligned();
    txn(0, 0, 16'h0003, SZ16, 1'b0, 16'h0000, 1'b0);
    txn(0, 1, 16'h0021, SZ16, 1'b1, 16'hDEAD, 1'b0);
    txn(0, 1, 16'h0020, SZ16, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_latency4();
    txn(1, 0, 16'h0010, SZ16, 1'b1, 16'h1234, 1'b0);
    txn(1, 1, 16'h0011, SZ8,  1'b0, 16'h0000, 1'b0);
    txn(1, 1, 16'h0007, SZ16, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int last, exp_ch, n, done;
    logic [15:0] ad [2];
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ad[0] = 16'h0010;
    ad[1] = 16'h0020;
    for (int c = 0; c < 2; c++) begin
      rdwr[0][c]             = 1'b1;
      addr_in[0][c*16 +: 16] = ad[c];
      sz_in[0][c]            = SZ16;
      we_in[0][c]            = 1'b0;
    end
    last = 1;
    n    = 0;
    done = 0;
    while (done < 6 && n < 40) begin
      @(negedge clk);
      n++;
      if (dr[0] != 2'b00) begin
        exp_ch = (last + 1) % 2;
        checks++;
        if (dr[0] !== 2'(1 << exp_ch)) begin
          errors++;
          $display("FAIL rr_grant #%0d got %b exp %b",
                   done, dr[0], 2'(1 << exp_ch));
        end
        checks++;
        if (rd[0][exp_ch*16 +: 16] !== ref_read(0, ad[exp_ch], SZ16)) begin
          errors++;
          $display("FAIL rr_rdata #%0d got %h exp %h", done,
                   rd[0][exp_ch*16 +: 16], ref_read(0, ad[exp_ch], SZ16));
        end
        checks++;
        if (n != 4) begin
          errors++;
          $display("FAIL rr_spacing #%0d got %0d exp 4", done, n);
        end
        last = exp_ch;
        n    = 0;
        done++;
      end
    end
    rdwr[0] = 2'b00;
    checks++;
    if (done != 6) begin
      errors++;
      $display("FAIL rr_timeout got %0d exp 6", done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    txn(1, 0, 16'h0010, SZ16, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rdwr[1][1]          = 1'b1;
    addr_in[1][31:16]   = 16'h0011;
    sz_in[1][1]         = SZ8;
    we_in[1][1]         = 1'b0;
    repeat (3) @(negedge clk);
    rdwr[1][0]          = 1'b1;
    addr_in[1][15:0]    = 16'h0010;
    sz_in[1][0]         = SZ16;
    we_in[1][0]         = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({dr[1], er[1], rd[1], m_en[1], m_we[1], m_addr[1],
         m_be[1], m_wd[1]} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got nonzero exp zero");
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (dr[1] == 2'b00 && n < 40);
      checks++;
      if (dr[1] !== 2'(1 << c) || n != 7) begin
        errors++;
        $display("FAIL reset_order #%0d got %b after %0d exp %b after 7",
                 c, dr[1], n, 2'(1 << c));
      end
      checks++;
      if (rd[1][c*16 +: 16] !==
          ref_read(1, addr_in[1][c*16 +: 16], sz_in[1][c])) begin
        errors++;
        $display("FAIL reset_rdata #%0d got %h exp %h", c, rd[1][c*16 +: 16],
                 ref_read(1, addr_in[1][c*16 +: 16], sz_in[1][c]));
      end
      rdwr[1][c] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int d, input int num);
    logic [15:0] a, wd;
    logic sz, we;
    int ch;
    bit drop;
    for (int i = 0; i < num; i++) begin
      a    = 16'($urandom_range(0, 127));
      ch   = $urandom_range(0, 1);
      sz   = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      wd   = 16'($urandom);
      drop = bit'($urandom_range(0, 1));
      txn(d, ch, a, sz, we, wd, drop);
    end
  endtask

  task automatic test_invariants();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (viol[d] != 0) begin
        errors++;
        $display("FAIL invariants d%0d got %0d exp 0", d, viol[d]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rdwr[d]    = '0;
      addr_in[d] = '0;
      sz_in[d]   = '0;
      we_in[d]   = '0;
      wd_in[d]   = '0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_basic16();
    test_byte_write();
    test_misaligned();
    test_latency4();
    test_back_to_back();
    test_reset_mid();
    test_random(0, 40);
    test_random(1, 12);
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jolt160_mem_arbiter.md
Name: jolt160_mem_arbiter

Overview:
Parametrised successor to the single-CPU/single-memory hookup. Arbitrates NUM_REQ requesters, each using the Jolt160 req_rdwr/data_ready handshake with 8/16-bit access size, onto one synchronous 16-bit RAM port with configurable read latency. Performs byte-lane steering and flags misaligned 16-bit accesses. Sits between jolt160 core(s)/debug/DMA masters and the shared memory.

Parameters:
NUM_REQ, 2, number of requester channels (1..8)
ADDR_WIDTH, 16, requester byte-address width
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (1..7)

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  asynchronous, active-high
req_rdwr  in  NUM_REQ  per-requester request, held high until its data_ready
req_addr  in  NUM_REQ*ADDR_WIDTH  byte address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_acc_sz  in  NUM_REQ  pkg_cpu::cpu_data_acc_sz_8 / _16
req_we  in  NUM_REQ  1 = write
req_wdata  in  NUM_REQ*16  write data (8-bit uses [7:0])
req_rdata  out  NUM_REQ*16  read data, valid while data_ready high
data_ready  out  NUM_REQ  one-cycle completion pulse per channel
req_err  out  NUM_REQ  misalign flag, valid with data_ready
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH-1  word address (req_addr >> 1)
mem_byte_en  out  2  lane enables, bit0 = even byte [7:0]
mem_wdata  out  16  RAM write data
mem_rdata  in  16  RAM read data

Behaviour:
- Reset (async): state IDLE, all outputs 0, wait counter 0, last_grant = NUM_REQ-1 (channel 0 wins first). Reset mid-transaction aborts it; no data_ready for the aborted channel.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req_rdwr high, grant via round-robin (first requesting channel after last_grant, wrapping), latch grant, addr, size, we, wdata; -> ISSUE. No request: stay.
- ISSUE (1 cycle): misaligned (acc_sz_16 and addr[0]=1) -> mem_en=0, go DONE with err. Otherwise mem_en=1, mem_we=latched we, mem_addr=addr>>1; -> WAIT, counter loaded with MEM_LATENCY.
- WAIT: decrement counter; on reaching 0 capture mem_rdata -> DONE.
- DONE (1 cycle): data_ready[grant]=1, req_err[grant]=err, req_rdata slice = steered data; all other slices 0. last_grant <= grant; -> IDLE.
- Latency: req sampled at edge 0 -> data_ready high after edge MEM_LATENCY+2, low after MEM_LATENCY+3. Misaligned: data_ready after edge 2. Writes use same latency as reads.
- Back-to-back: requester keeping req_rdwr high after data_ready is a new request, sampled in the following IDLE cycle (minimum 1 idle cycle between transactions).
- 16-bit: byte_en=2'b11, wdata passthrough, rdata passthrough.
- 8-bit: byte_en = addr[0] ? 2'b10 : 2'b01; wdata byte replicated on both lanes; read returns selected lane zero-extended in [7:0].
- Misaligned: no RAM access, rdata=0, req_err=1.
- req_rdwr dropped by granted channel mid-transaction: transaction completes anyway (latched).
- mem_we/mem_byte_en/mem_addr/mem_wdata are 0 whenever mem_en=0.

Decomposition:
- pkg_cpu: add mem_arb_state_t enum (IDLE, ISSUE, WAIT, DONE); reuse cpu_data_acc_sz_8/_16.
- Sub-module rr_arbiter #(NUM_REQ): combinational round-robin grant (one-hot + index) from req vector and last_grant.

Test Plan:
- MEM_LATENCY=1, ch0 16-bit read addr 0x0010, RAM word 8 = 0xBEEF -> mem_addr=0x0008, byte_en=11, data_ready[0] pulses 3 edges after sample, rdata0=0xBEEF.
- ch1 8-bit write 0x5A to addr 0x0021 -> mem_byte_en=10, mem_wdata=0x5A5A; readback 16-bit addr 0x0020 -> upper byte 0x5A, lower byte unchanged.
- ch0 and ch1 request together continuously after reset -> grants alternate 0,1,0,1; each data_ready one cycle, never both high.
- ch0 16-bit read addr 0x0003 -> mem_en never high, data_ready[0] and req_err[0] high 2 edges after sample, rdata0=0.
- MEM_LATENCY=4, 8-bit read addr 0x0011, word 0x1234 -> rdata=0x0012, data_ready after 6 edges.
- Assert reset during WAIT -> all outputs 0 immediately; after release, pending ch1 served first? No: ch0 first (last_grant reset), no stale data_ready.
